issue_scoreboard: RTL and testbench



---
 rtl/sb_pkg.sv | 18 +
 rtl/issue_scoreboard_if.sv | 30 +++
 rtl/sb_reg_counter.sv | 49 ++++
 rtl/issue_scoreboard.sv | 82 ++++++++
 tb/tb_issue_scoreboard.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/sb_pkg.sv
// Shared types and constants for the issue scoreboard.
package sb_pkg;

   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
   } sb_port_t;

   function automatic logic port_hit(sb_port_t p, reg_idx_t r);
      return p.valid && (p.rd == r);
   endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue/writeback/flush pulses in and busy/status out for the issue scoreboard.
interface issue_scoreboard_if #(parameter int NUM_REGS = 32);

   logic                  issue_a_valid;
   sb_pkg::reg_idx_t      issue_a_rd;
   logic                  issue_b_valid;
   sb_pkg::reg_idx_t      issue_b_rd;
   logic                  wb_a_valid;
   sb_pkg::reg_idx_t      wb_a_rd;
   logic                  wb_b_valid;
   sb_pkg::reg_idx_t      wb_b_rd;
   logic                  flush;
   logic [NUM_REGS-1:0]   scoreboard;
   logic                  idle;
   logic                  overflow_err;
   logic                  underflow_err;

   modport master (
      output issue_a_valid, issue_a_rd, issue_b_valid, issue_b_rd,
      output wb_a_valid, wb_a_rd, wb_b_valid, wb_b_rd, flush,
      input  scoreboard, idle, overflow_err, underflow_err
   );

   modport slave (
      input  issue_a_valid, issue_a_rd, issue_b_valid, issue_b_rd,
      input  wb_a_valid, wb_a_rd, wb_b_valid, wb_b_rd, flush,
      output scoreboard, idle, overflow_err, underflow_err
   );

endinterface

// File: rtl/sb_reg_counter.sv
// Saturating in-flight write counter for one architectural register.
module sb_reg_counter #(
   parameter int CNT_W = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] inc,
   input  logic [1:0] dec,
   input  logic       flush,
   output logic       busy,
   output logic       busy_bypass,
   output logic       ovf,
   output logic       udf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nxt;
   logic signed [CNT_W+1:0] sum;

   always_comb begin
      sum     = $signed({2'b00, cnt})
              + $signed({{CNT_W{1'b0}}, inc})
              - $signed({{CNT_W{1'b0}}, dec});
      cnt_nxt = sum[CNT_W-1:0];
      ovf     = 1'b0;
      udf     = 1'b0;
      if (flush) begin
         cnt_nxt = '0;
      end else if (sum < 0) begin
         cnt_nxt = '0;
         udf     = 1'b1;
      end else if (sum > $signed({2'b00, CNT_MAX})) begin
         cnt_nxt = CNT_MAX;
         ovf     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nxt;
   end

   assign busy = |cnt;
   // Busy after this cycle's retirements only; same-cycle issues deliberately excluded.
   assign busy_bypass = ({2'b00, cnt} > {{CNT_W{1'b0}}, dec});

endmodule

// File: rtl/issue_scoreboard.sv
// Per-register in-flight write scoreboard for the dual-issue pipe.
// Define SB_WB_BYPASS_EN to let a final writeback clear its busy bit in the same cycle.
module issue_scoreboard
   import sb_pkg::*;
#(
   parameter int NUM_REGS = sb_pkg::NUM_REGS,
   parameter int CNT_W    = 2
) (
   input logic               clk,
   input logic               rst_n,
   issue_scoreboard_if.slave sb_if
);

   sb_port_t issue_a, issue_b, wb_a, wb_b;

   assign issue_a = '{valid: sb_if.issue_a_valid, rd: sb_if.issue_a_rd};
   assign issue_b = '{valid: sb_if.issue_b_valid, rd: sb_if.issue_b_rd};
   assign wb_a    = '{valid: sb_if.wb_a_valid,    rd: sb_if.wb_a_rd};
   assign wb_b    = '{valid: sb_if.wb_b_valid,    rd: sb_if.wb_b_rd};

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_bypass;
   logic [NUM_REGS-1:0] ovf;
   logic [NUM_REGS-1:0] udf;
   logic [NUM_REGS-1:0] busy_vec;
   logic                ovf_q;
   logic                udf_q;

   // x0 is hardwired: never busy, never raises an error.
   assign busy[0]        = 1'b0;
   assign busy_bypass[0] = 1'b0;
   assign ovf[0]         = 1'b0;
   assign udf[0]         = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      logic [1:0] inc;
      logic [1:0] dec;

      assign inc = {1'b0, port_hit(issue_a, reg_idx_t'(r))}
                 + {1'b0, port_hit(issue_b, reg_idx_t'(r))};
      assign dec = {1'b0, port_hit(wb_a, reg_idx_t'(r))}
                 + {1'b0, port_hit(wb_b, reg_idx_t'(r))};

      sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk         (clk),
         .rst_n       (rst_n),
         .inc         (inc),
         .dec         (dec),
         .flush       (sb_if.flush),
         .busy        (busy[r]),
         .busy_bypass (busy_bypass[r]),
         .ovf         (ovf[r]),
         .udf         (udf[r])
      );
   end

`ifdef SB_WB_BYPASS_EN
   assign busy_vec = busy_bypass;
   logic sb_unused_busy;
   assign sb_unused_busy = ^busy;
`else
   assign busy_vec = busy;
   logic sb_unused_bypass;
   assign sb_unused_bypass = ^busy_bypass;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (|ovf);
         udf_q <= udf_q | (|udf);
      end
   end

   assign sb_if.scoreboard    = busy_vec;
   assign sb_if.idle          = ~|busy_vec;
   assign sb_if.overflow_err  = ovf_q;
   assign sb_if.underflow_err = udf_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard (base and SB_WB_BYPASS_EN builds).
module tb_issue_scoreboard;
   import sb_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   issue_scoreboard_if #(.NUM_REGS(32)) sb_if ();

   issue_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb_if (sb_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      sb_if.issue_a_valid = 1'b0; sb_if.issue_a_rd = '0;
      sb_if.issue_b_valid = 1'b0; sb_if.issue_b_rd = '0;
      sb_if.wb_a_valid    = 1'b0; sb_if.wb_a_rd    = '0;
      sb_if.wb_b_valid    = 1'b0; sb_if.wb_b_rd    = '0;
      sb_if.flush         = 1'b0;
   endtask

   // Clock the currently driven pulses in, then drop them.
   task automatic tick();
      @(posedge clk);
      #1;
      clear_inputs();
      #1;
   endtask

   task automatic check_status(input string tag, input logic [31:0] sb, input logic idle,
                               input logic ovf, input logic udf);
      check_val({tag, "_sb"},   sb_if.scoreboard,           sb);
      check_val({tag, "_idle"}, {31'b0, sb_if.idle},         {31'b0, idle});
      check_val({tag, "_ovf"},  {31'b0, sb_if.overflow_err}, {31'b0, ovf});
      check_val({tag, "_udf"},  {31'b0, sb_if.underflow_err},{31'b0, udf});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      check_status("reset", 32'h0, 1'b1, 1'b0, 1'b0);

      // Single issue then writeback of x5.
      sb_if.issue_a_valid = 1'b1; sb_if.issue_a_rd = 5'd5;
      #1 check_val("issue5_same_cycle", sb_if.scoreboard, 32'h0);
      tick();
      check_val("issue5_next_sb", sb_if.scoreboard, 32'h20);
      check_val("issue5_next_idle", {31'b0, sb_if.idle}, 32'h0);
      tick();
      tick();
      sb_if.wb_a_valid = 1'b1; sb_if.wb_a_rd = 5'd5;
      #1;
`ifdef SB_WB_BYPASS_EN
      check_val("wb5_same_cycle", sb_if.scoreboard, 32'h0);
`else
      check_val("wb5_same_cycle", sb_if.scoreboard, 32'h20);
`endif
      tick();
      check_val("wb5_next_sb", sb_if.scoreboard, 32'h0);
      check_val("wb5_next_idle", {31'b0, sb_if.idle}, 32'h1);

      // Dual issue to x7, two separate retirements.
      sb_if.issue_a_valid = 1'b1; sb_if.issue_a_rd = 5'd7;
      sb_if.issue_b_valid = 1'b1; sb_if.issue_b_rd = 5'd7;
      tick();
      check_val("dual7_sb", sb_if.scoreboard, 32'h80);
      sb_if.wb_a_valid = 1'b1; sb_if.wb_a_rd = 5'd7;
      #1 check_val("dual7_wb1_bypass", sb_if.scoreboard, 32'h80);
      tick();
      check_val("dual7_wb1_sb", sb_if.scoreboard, 32'h80);
      sb_if.wb_b_valid = 1'b1; sb_if.wb_b_rd = 5'd7;
      tick();
      check_status("dual7_wb2", 32'h0, 1'b1, 1'b0, 1'b0);

      // Net issue+writeback in one cycle on x8 holding one write.
      sb_if.issue_a_valid = 1'b1; sb_if.issue_a_rd = 5'd8;
      tick();
      sb_if.issue_b_valid = 1'b1; sb_if.issue_b_rd = 5'd8;
      sb_if.wb_a_valid    = 1'b1; sb_if.wb_a_rd    = 5'd8;
      tick();
      check_val("net8_sb", sb_if.scoreboard, 32'h100);
      sb_if.wb_b_valid = 1'b1; sb_if.wb_b_rd = 5'd8;
      tick();
      check_val("net8_clear", sb_if.scoreboard, 32'h0);

      // x0 is never tracked.
      for (int i = 0; i < 3; i++) begin
         sb_if.issue_a_valid = 1'b1; sb_if.issue_a_rd = 5'd0;
         sb_if.wb_b_valid    = 1'b1; sb_if.wb_b_rd    = 5'd0;
         tick();
      end
      sb_if.wb_a_valid = 1'b1; sb_if.wb_a_rd = 5'd0;
      sb_if.wb_b_valid = 1'b1; sb_if.wb_b_rd = 5'd0;
      tick();
      check_status("x0", 32'h0, 1'b1, 1'b0, 1'b0);

      // Saturation on x3.
      for (int i = 0; i < 4; i++) begin
         sb_if.issue_a_valid = 1'b1; sb_if.issue_a_rd = 5'd3;
         tick();
         if (i == 2) check_val("ovf3_before", {31'b0, sb_if.overflow_err}, 32'h0);
      end
      check_val("ovf3_after", {31'b0, sb_if.overflow_err}, 32'h1);
      check_val("ovf3_sb", sb_if.scoreboard, 32'h8);
      for (int i = 0; i < 3; i++) begin
         sb_if.wb_a_valid = 1'b1; sb_if.wb_a_rd = 5'd3;
         tick();
         if (i == 1) check_val("sat3_wb2_sb", sb_if.scoreboard, 32'h8);
      end
      check_status("sat3_drained", 32'h0, 1'b1, 1'b1, 1'b0);

      // Flush beats concurrent issue and writeback.
      sb_if.issue_a_valid = 1'b1; sb_if.issue_a_rd = 5'd1;
      sb_if.issue_b_valid = 1'b1; sb_if.issue_b_rd = 5'd2;
      tick();
      sb_if.issue_a_valid = 1'b1; sb_if.issue_a_rd = 5'd9;
      tick();
      check_val("preflush_sb", sb_if.scoreboard, 32'h206);
      sb_if.flush         = 1'b1;
      sb_if.issue_a_valid = 1'b1; sb_if.issue_a_rd = 5'd4;
      sb_if.wb_a_valid    = 1'b1; sb_if.wb_a_rd    = 5'd1;
      sb_if.wb_b_valid    = 1'b1; sb_if.wb_b_rd    = 5'd6;
      tick();
      check_status("flush", 32'h0, 1'b1, 1'b1, 1'b0);
      sb_if.wb_a_valid = 1'b1; sb_if.wb_a_rd = 5'd1;
      tick();
      check_val("udf1", {31'b0, sb_if.underflow_err}, 32'h1);
      check_val("udf1_sb", sb_if.scoreboard, 32'h0);

      // Asynchronous reset between clock edges.
      sb_if.issue_a_valid = 1'b1; sb_if.issue_a_rd = 5'd6;
      tick();
      check_val("prerst_sb", sb_if.scoreboard, 32'h40);
      #1 rst_n = 1'b0;
      #1 check_status("async_rst", 32'h0, 1'b1, 1'b0, 1'b0);
      #1 rst_n = 1'b1;
      tick();
      tick();
      check_status("post_rst", 32'h0, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
